// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator key-entry sequencer.
//   - key code constants (digits are 0..9)
//   - operator enum driven on OpCode
//   - sequencer state enum
//   - display source select constants
//   - helpers that classify a key code and map an operator key to an OpCode
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_SHOW_RES = 3'd4
  } state_e;

  localparam logic [1:0] DISP_OPA = 2'd0;
  localparam logic [1:0] DISP_OPB = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  typedef enum logic [1:0] {
    KC_DIGIT = 2'd0,
    KC_OP    = 2'd1,
    KC_EQ    = 2'd2,
    KC_CLR   = 2'd3
  } key_class_e;

  function automatic key_class_e key_class(input logic [3:0] code);
    if (code <= 4'd9) begin
      return KC_DIGIT;
    end else if (code <= KEY_DIV) begin
      return KC_OP;
    end else if (code == KEY_EQ) begin
      return KC_EQ;
    end else begin
      return KC_CLR;
    end
  endfunction

  function automatic op_e key_to_op(input logic [3:0] code);
    case (code)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      KEY_DIV: return OP_DIV;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_key_debounce.sv
// calc_key_debounce: turns the scanner's KeyRead/BCDKey level into a single
// accepted-key strobe per physical press.
//   clk, rst_n      clock, async active-low reset
//   key_read_i      scanner: a key is held
//   key_code_i      scanner key code
//   hold_i          force release-armed (used while the keypad is disabled)
//   key_stb_o       one-cycle strobe on the DEBOUNCE_CYC-th stable cycle
//   key_code_o      code accompanying key_stb_o
// After a strobe (and out of reset) the block is release-armed: it must see
// KeyRead=0 for DEBOUNCE_CYC consecutive cycles before counting a press.
module calc_key_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_read_i,
  input  logic [3:0] key_code_i,
  input  logic       hold_i,
  output logic       key_stb_o,
  output logic [3:0] key_code_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  // cnt_q counts qualifying cycles already seen in the current phase
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          rel_q, rel_d;

  // Press/release qualification and strobe generation
  always_comb begin
    cnt_d     = cnt_q;
    code_d    = code_q;
    rel_d     = rel_q;
    key_stb_o = 1'b0;
    if (hold_i) begin
      rel_d = 1'b1;
      cnt_d = CNT_ZERO;
    end else if (rel_q) begin
      if (!key_read_i) begin
        if (cnt_q == CNT_LAST) begin
          rel_d = 1'b0;
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else begin
      if (key_read_i) begin
        if ((cnt_q != CNT_ZERO) && (key_code_i != code_q)) begin
          // code changed mid-press: this cycle starts a fresh count
          cnt_d  = CNT_ONE;
          code_d = key_code_i;
        end else if (cnt_q == CNT_LAST) begin
          key_stb_o = 1'b1;
          rel_d     = 1'b1;
          cnt_d     = CNT_ZERO;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          code_d = key_code_i;
        end
      end else begin
        cnt_d = CNT_ZERO;
      end
    end
  end

  assign key_code_o = code_q;

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= CNT_ZERO;
      code_q <= 4'd0;
      rel_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      code_q <= code_d;
      rel_q  <= rel_d;
    end
  end

endmodule

// File: rtl/calc_entry_seq.sv
// calc_entry_seq: calculator key-entry sequencer.
//   CLK, RESET_N        clock, async active-low reset
//   KeyRead, BCDKey     keypad scanner level inputs
//   EnableKeyb          scanner enable (low while an operation is in flight)
//   OpA, OpB, OpCode    operands (BCD, LS digit in [3:0]) and operator
//   OpValid / OpReady   request handshake toward the arithmetic unit
//   ResValid, ResBCD    result strobe and value
//   DispSel             display source: 0 OpA, 1 OpB, 2 result
//   Err                 one-cycle pulse when a key is rejected
module calc_entry_seq
  import calc_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              KeyRead,
  input  logic [3:0]        BCDKey,
  output logic              EnableKeyb,
  output logic [4*NDIG-1:0] OpA,
  output logic [4*NDIG-1:0] OpB,
  output logic [1:0]        OpCode,
  output logic              OpValid,
  input  logic              OpReady,
  input  logic              ResValid,
  input  logic [4*NDIG-1:0] ResBCD,
  output logic [1:0]        DispSel,
  output logic              Err
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] DIG_ZERO = CW'(0);
  localparam logic [CW-1:0] DIG_ONE  = CW'(1);
  localparam logic [CW-1:0] DIG_MAX  = CW'(NDIG);

  function automatic logic [W-1:0] shift_digit(input logic [W-1:0] v, input logic [3:0] d);
    return {v[W-5:0], d};
  endfunction

  state_e        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  op_e           opcode_q, opcode_d;
  logic [CW-1:0] cnta_q, cnta_d, cntb_q, cntb_d;
  logic          err_q, err_d;
  logic [1:0]    disp_q, disp_d;
  logic          opvalid_q, opvalid_d;
  logic          enkb_q, enkb_d;
  logic          clr_s;
  logic          key_stb_s;
  logic [3:0]    key_code_s;
  key_class_e    cls_s;

  calc_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .key_read_i (KeyRead),
    .key_code_i (BCDKey),
    .hold_i     (~enkb_q),
    .key_stb_o  (key_stb_s),
    .key_code_o (key_code_s)
  );

  assign cls_s = key_class(key_code_s);

  // Sequencer next-state: key interpretation, handshake and result capture
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    opcode_d = opcode_q;
    cnta_d   = cnta_q;
    cntb_d   = cntb_q;
    err_d    = 1'b0;
    clr_s    = 1'b0;
    case (state_q)
      ST_ENTER_A: begin
        if (key_stb_s) begin
          case (cls_s)
            KC_DIGIT: begin
              if (cnta_q < DIG_MAX) begin
                opa_d  = shift_digit(opa_q, key_code_s);
                cnta_d = cnta_q + DIG_ONE;
              end else begin
                err_d = 1'b1;
              end
            end
            KC_OP: begin
              opcode_d = key_to_op(key_code_s);
              opb_d    = '0;
              cntb_d   = DIG_ZERO;
              state_d  = ST_ENTER_B;
            end
            KC_CLR:  clr_s = 1'b1;
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_ENTER_B: begin
        if (key_stb_s) begin
          case (cls_s)
            KC_DIGIT: begin
              if (cntb_q < DIG_MAX) begin
                opb_d  = shift_digit(opb_q, key_code_s);
                cntb_d = cntb_q + DIG_ONE;
              end else begin
                err_d = 1'b1;
              end
            end
            KC_OP: begin
              // operator may only be changed before any B digit is typed
              if (cntb_q == DIG_ZERO) begin
                opcode_d = key_to_op(key_code_s);
              end else begin
                err_d = 1'b1;
              end
            end
            KC_EQ: begin
              if (cntb_q != DIG_ZERO) begin
                state_d = ST_ISSUE;
              end else begin
                err_d = 1'b1;
              end
            end
            KC_CLR:  clr_s = 1'b1;
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_ISSUE: begin
        if (OpReady) begin
          state_d = ST_WAIT_RES;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RES: begin
        if (ResValid) begin
          res_d   = ResBCD;
          state_d = ST_SHOW_RES;
        end else begin
          state_d = ST_WAIT_RES;
        end
      end
      ST_SHOW_RES: begin
        if (key_stb_s) begin
          case (cls_s)
            KC_DIGIT: begin
              opa_d   = {{(W-4){1'b0}}, key_code_s};
              opb_d   = '0;
              cnta_d  = DIG_ONE;
              cntb_d  = DIG_ZERO;
              state_d = ST_ENTER_A;
            end
            KC_OP: begin
              // chain: the result becomes a full-length operand A
              opa_d    = res_q;
              cnta_d   = DIG_MAX;
              opcode_d = key_to_op(key_code_s);
              opb_d    = '0;
              cntb_d   = DIG_ZERO;
              state_d  = ST_ENTER_B;
            end
            KC_CLR:  clr_s = 1'b1;
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_ENTER_A;
      end
    endcase
    if (clr_s) begin
      opa_d    = '0;
      opb_d    = '0;
      res_d    = '0;
      opcode_d = OP_ADD;
      cnta_d   = DIG_ZERO;
      cntb_d   = DIG_ZERO;
      state_d  = ST_ENTER_A;
    end else begin
      err_d = err_d;
    end
  end

  // Output decode from the next state so that outputs come straight from flops
  always_comb begin
    disp_d    = DISP_OPA;
    opvalid_d = 1'b0;
    enkb_d    = 1'b1;
    case (state_d)
      ST_ENTER_A:  disp_d = DISP_OPA;
      ST_ENTER_B:  disp_d = DISP_OPB;
      ST_ISSUE: begin
        disp_d    = DISP_OPB;
        opvalid_d = 1'b1;
        enkb_d    = 1'b0;
      end
      ST_WAIT_RES: begin
        disp_d = DISP_OPB;
        enkb_d = 1'b0;
      end
      ST_SHOW_RES: disp_d = DISP_RES;
      default:     disp_d = DISP_OPA;
    endcase
  end

  // Sequencer state and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_ENTER_A;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      opcode_q  <= OP_ADD;
      cnta_q    <= DIG_ZERO;
      cntb_q    <= DIG_ZERO;
      err_q     <= 1'b0;
      disp_q    <= DISP_OPA;
      opvalid_q <= 1'b0;
      enkb_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      opcode_q  <= opcode_d;
      cnta_q    <= cnta_d;
      cntb_q    <= cntb_d;
      err_q     <= err_d;
      disp_q    <= disp_d;
      opvalid_q <= opvalid_d;
      enkb_q    <= enkb_d;
    end
  end

  assign OpA        = opa_q;
  assign OpB        = opb_q;
  assign OpCode     = opcode_q;
  assign OpValid    = opvalid_q;
  assign EnableKeyb = enkb_q;
  assign DispSel    = disp_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Bench for calc_entry_seq: directed scenarios plus a random key stream,
// checked against an abstract key-by-key calculator model.
module tb_calc_entry_seq;

  localparam int NDIG = 4;
  localparam int DEB  = 4;
  localparam int W    = 4 * NDIG;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         KeyRead = 1'b0;
  logic [3:0]   BCDKey = 4'd0;
  logic         OpReady = 1'b0;
  logic         ResValid = 1'b0;
  logic [W-1:0] ResBCD = '0;
  logic         EnableKeyb;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic [1:0]   OpCode;
  logic         OpValid;
  logic [1:0]   DispSel;
  logic         Err;

  calc_entry_seq #(.NDIG(NDIG), .DEBOUNCE_CYC(DEB)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .KeyRead    (KeyRead),
    .BCDKey     (BCDKey),
    .EnableKeyb (EnableKeyb),
    .OpA        (OpA),
    .OpB        (OpB),
    .OpCode     (OpCode),
    .OpValid    (OpValid),
    .OpReady    (OpReady),
    .ResValid   (ResValid),
    .ResBCD     (ResBCD),
    .DispSel    (DispSel),
    .Err        (Err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  int err_seen = 0;

  always @(negedge CLK) begin
    if (Err === 1'b1) err_seen <= err_seen + 1;
  end

  // Abstract model: 0 entering A, 1 entering B, 2 operation in flight, 3 showing result
  int m_a, m_b, m_op, m_res, m_na, m_nb, m_st;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_na = 0; m_nb = 0; m_st = 0;
  endfunction

  // Returns 1 when the key should be rejected
  function automatic bit model_key(input int k);
    if (k == 15) begin
      model_reset();
      return 1'b0;
    end
    if (m_st == 0 || m_st == 1) begin
      if (k < 10) begin
        if (m_st == 0 && m_na < NDIG) begin m_a = m_a * 16 + k; m_na++; return 1'b0; end
        if (m_st == 1 && m_nb < NDIG) begin m_b = m_b * 16 + k; m_nb++; return 1'b0; end
        return 1'b1;
      end
      if (k < 14) begin
        if (m_st == 1 && m_nb > 0) return 1'b1;
        m_op = k - 10;
        if (m_st == 0) begin m_b = 0; m_nb = 0; m_st = 1; end
        return 1'b0;
      end
      if (m_st == 1 && m_nb > 0) begin m_st = 2; return 1'b0; end
      return 1'b1;
    end
    if (k < 10) begin
      m_a = k; m_na = 1; m_b = 0; m_nb = 0; m_st = 0;
      return 1'b0;
    end
    if (k < 14) begin
      m_a = m_res; m_na = NDIG; m_op = k - 10; m_b = 0; m_nb = 0; m_st = 1;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    KeyRead = 1'b1;
    BCDKey  = code;
    cyc(hold);
    KeyRead = 1'b0;
    BCDKey  = 4'($urandom);
    cyc(rel);
  endtask

  task automatic check_state(input string tag);
    int ds;
    @(negedge CLK);
    check_eq({tag, "/opa"}, 32'(OpA), 32'(m_a));
    check_eq({tag, "/opb"}, 32'(OpB), 32'(m_b));
    check_eq({tag, "/opcode"}, 32'(OpCode), 32'(m_op));
    if (m_st == 2) begin
      check_eq({tag, "/opvalid"}, 32'(OpValid), 32'd1);
      check_eq({tag, "/enkb"}, 32'(EnableKeyb), 32'd0);
    end else begin
      ds = (m_st == 0) ? 0 : (m_st == 1) ? 1 : 2;
      check_eq({tag, "/opvalid"}, 32'(OpValid), 32'd0);
      check_eq({tag, "/dispsel"}, 32'(DispSel), 32'(ds));
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_key(input int k);
    int e0;
    bit exp_err;
    exp_err = model_key(k);
    e0 = err_seen;
    press(4'(k), 10, 10);
    check_eq("err_pulses", 32'(err_seen - e0), 32'(exp_err));
    check_state("key");
  endtask

  task automatic do_issue(input int dly, input logic [W-1:0] res);
    cyc(dly);
    @(negedge CLK);
    check_eq("issue/opvalid_held", 32'(OpValid), 32'd1);
    check_eq("issue/opa_held", 32'(OpA), 32'(m_a));
    check_eq("issue/opb_held", 32'(OpB), 32'(m_b));
    @(posedge CLK); #1;
    // result strobe coinciding with the handshake must be ignored
    OpReady = 1'b1; ResValid = 1'b1; ResBCD = 16'h9999;
    cyc(1);
    OpReady = 1'b0; ResValid = 1'b0; ResBCD = '0;
    @(negedge CLK);
    check_eq("wait/opvalid", 32'(OpValid), 32'd0);
    check_eq("wait/enkb", 32'(EnableKeyb), 32'd0);
    @(posedge CLK); #1;
    cyc(2);
    ResValid = 1'b1; ResBCD = res;
    cyc(1);
    ResValid = 1'b0; ResBCD = '0;
    m_res = 32'(res);
    m_st = 3;
    @(negedge CLK);
    check_eq("show/dispsel", 32'(DispSel), 32'd2);
    check_eq("show/enkb", 32'(EnableKeyb), 32'd1);
    @(posedge CLK); #1;
    cyc(6);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) v = {v[W-5:0], 4'($urandom_range(0, 9))};
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "/opvalid"}, 32'(OpValid), 32'd0);
    check_eq({tag, "/enkb"}, 32'(EnableKeyb), 32'd1);
    check_eq({tag, "/opa"}, 32'(OpA), 32'd0);
    check_eq({tag, "/opb"}, 32'(OpB), 32'd0);
    check_eq({tag, "/opcode"}, 32'(OpCode), 32'd0);
    check_eq({tag, "/dispsel"}, 32'(DispSel), 32'd0);
    check_eq({tag, "/err"}, 32'(Err), 32'd0);
  endtask

  initial begin
    int k;
    int e0;
    int seq0[7];
    seq0 = '{1, 2, 3, 10, 4, 5, 14};
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    cyc(8);

    // basic entry, then issue with a stalled arithmetic unit, then chain with SUB
    foreach (seq0[i]) do_key(seq0[i]);
    check_eq("basic/opa", 32'(OpA), 32'h0123);
    check_eq("basic/opb", 32'(OpB), 32'h0045);
    do_issue(10, 16'h0168);
    do_key(11);
    check_eq("chain/opa", 32'(OpA), 32'h0168);

    // long hold gives a single digit
    do_key(15);
    void'(model_key(7));
    e0 = err_seen;
    press(4'd7, 50, 10);
    check_eq("hold/err", 32'(err_seen - e0), 32'd0);
    check_state("hold");
    check_eq("hold/opa", 32'(OpA), 32'h0007);

    // short glitches and a code change mid-press give no strobe
    repeat (3) begin
      KeyRead = 1'b1; BCDKey = 4'd9; cyc(DEB - 1);
      KeyRead = 1'b0; cyc(5);
    end
    KeyRead = 1'b1; BCDKey = 4'd8; cyc(DEB - 1);
    BCDKey = 4'd9; cyc(DEB - 1);
    KeyRead = 1'b0; cyc(6);
    check_state("glitch");

    // digit overflow
    do_key(15);
    for (int d = 1; d <= 5; d++) do_key(d);
    check_eq("overflow/opa", 32'(OpA), 32'h1234);

    // operator replacement, late operator rejected, clear
    do_key(10);
    do_key(12);
    check_eq("replace/opcode", 32'(OpCode), 32'd2);
    do_key(3);
    do_key(11);
    check_eq("late_op/opcode", 32'(OpCode), 32'd2);
    do_key(15);

    // reset while a request is pending
    do_key(1); do_key(10); do_key(2); do_key(14);
    cyc(3);
    #2;
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    cyc(8);
    check_state("after_reset");

    // random key stream
    repeat (70) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: k = $urandom_range(0, 9);
        5, 6:          k = $urandom_range(10, 13);
        7, 8:          k = 14;
        default:       k = 15;
      endcase
      do_key(k);
      if (m_st == 2) do_issue($urandom_range(0, 12), rand_bcd());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
